// File: rtl/store_burst_ctrl.sv
`timescale 1ns/1ps
// store_burst_ctrl
// Sequences one accumulator store. It loads the store-data mux register word by
// word through store_data_reg_wr_en/sel_store_data and issues one AXI4 INCR write
// burst (AW, then W beats 0..len, then B) on the m_axi_memory_bus master port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  command strobe, sampled only when idle
//   base_addr_i, len_i       burst start address, beat count minus one
//   busy_o, done_o, err_o    status: active, completion pulse, BRESP[1] of last burst
//   store_data_reg_wr_en     load enable for the WDATA mux register
//   sel_store_data           accumulator word index for that mux
//   m_axi_memory_bus_*       AXI4 write address / write data / write response channels
module store_burst_ctrl #(
    parameter int unsigned AXI_WIDTH_ID = 4,
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 32,
    parameter int unsigned AXI_WIDTH_DS = AXI_WIDTH_DA / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [AXI_WIDTH_AD-1:0] base_addr_i,
    input  logic [4:0]              len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    store_data_reg_wr_en,
    output logic [4:0]              sel_store_data,
    output logic [AXI_WIDTH_ID-1:0] m_axi_memory_bus_AWID,
    output logic [AXI_WIDTH_AD-1:0] m_axi_memory_bus_AWADDR,
    output logic [7:0]              m_axi_memory_bus_AWLEN,
    output logic [2:0]              m_axi_memory_bus_AWSIZE,
    output logic [1:0]              m_axi_memory_bus_AWBURST,
    output logic                    m_axi_memory_bus_AWVALID,
    input  logic                    m_axi_memory_bus_AWREADY,
    output logic [AXI_WIDTH_DS-1:0] m_axi_memory_bus_WSTRB,
    output logic                    m_axi_memory_bus_WLAST,
    output logic                    m_axi_memory_bus_WVALID,
    input  logic                    m_axi_memory_bus_WREADY,
    input  logic [AXI_WIDTH_ID-1:0] m_axi_memory_bus_BID,
    input  logic [1:0]              m_axi_memory_bus_BRESP,
    input  logic                    m_axi_memory_bus_BVALID,
    output logic                    m_axi_memory_bus_BREADY
);

    localparam int unsigned LEN_W     = 5;
    localparam int unsigned AXSIZE    = $clog2(AXI_WIDTH_DS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_LOAD,
        S_W,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        beat_q, beat_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    wr_en_c;
    logic [LEN_W-1:0]        sel_c;
    logic                    last_beat;

    // BID and BRESP[0] carry no information for this block.
    logic unused_b;
    assign unused_b = ^{m_axi_memory_bus_BID, m_axi_memory_bus_BRESP[0]};

    assign last_beat = (beat_q == len_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state and mux-register control.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        addr_d  = addr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        wr_en_c = 1'b0;
        sel_c   = beat_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_AW;
                    addr_d  = base_addr_i;
                    len_d   = len_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_AW: begin
                if (m_axi_memory_bus_AWREADY) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Preload word 0 so WDATA is valid on the first W cycle.
                wr_en_c = 1'b1;
                state_d = S_W;
            end
            S_W: begin
                if (m_axi_memory_bus_WREADY) begin
                    if (last_beat) begin
                        state_d = S_RESP;
                    end else begin
                        // Load the next word in the same cycle the current one is taken.
                        wr_en_c = 1'b1;
                        sel_c   = LEN_W'(beat_q + LEN_W'(1));
                        beat_d  = LEN_W'(beat_q + LEN_W'(1));
                    end
                end
            end
            S_RESP: begin
                if (m_axi_memory_bus_BVALID) begin
                    err_d   = m_axi_memory_bus_BRESP[1];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o                   = (state_q != S_IDLE);
    assign done_o                   = done_q;
    assign err_o                    = err_q;
    assign store_data_reg_wr_en     = wr_en_c;
    assign sel_store_data           = sel_c;

    assign m_axi_memory_bus_AWID    = '0;
    assign m_axi_memory_bus_AWADDR  = addr_q;
    assign m_axi_memory_bus_AWLEN   = {3'b000, len_q};
    assign m_axi_memory_bus_AWSIZE  = 3'(AXSIZE);
    assign m_axi_memory_bus_AWBURST = 2'b01;
    assign m_axi_memory_bus_AWVALID = (state_q == S_AW);
    assign m_axi_memory_bus_WSTRB   = '1;
    assign m_axi_memory_bus_WVALID  = (state_q == S_W);
    assign m_axi_memory_bus_WLAST   = (state_q == S_W) && last_beat;
    assign m_axi_memory_bus_BREADY  = (state_q == S_RESP);

endmodule

// File: doc/store_burst_ctrl.md
# store_burst_ctrl

Sequencer for the accumulator store path. It takes a store command (base address, beat count) and drives `store_data_reg_wr_en`/`sel_store_data` into the store-data mux register. It also runs one AXI4 INCR write burst (AW, W, B channels) whose W beats are the selected accumulator words, in order 0..len. It sits between the layer controller, which issues the store command, and the `m_axi_memory_bus` master port; the mux register supplies WDATA.

## Interface
- AXI_WIDTH_ID, 4, AXI ID width
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width (one accumulator word per beat)
- AXI_WIDTH_DS, AXI_WIDTH_DA/8, strobe width
- clk  in  1  clock; one clock domain for the whole block
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  command strobe; sampled only in IDLE
- base_addr_i  in  AXI_WIDTH_AD  burst start address; aligned to AXI_WIDTH_DS
- len_i  in  5  beats-1 (0..31)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the B response is accepted
- err_o  out  1  BRESP[1] of the last burst; cleared on accepted start
- store_data_reg_wr_en  out  1  load enable for the WDATA mux register
- sel_store_data  out  5  word index for the mux
- m_axi_memory_bus_AWID  out  AXI_WIDTH_ID  constant 0
- m_axi_memory_bus_AWADDR  out  AXI_WIDTH_AD  latched base_addr_i
- m_axi_memory_bus_AWLEN  out  8  {3'b0, latched len}
- m_axi_memory_bus_AWSIZE  out  3  log2(AXI_WIDTH_DS)
- m_axi_memory_bus_AWBURST  out  2  2'b01 (INCR)
- m_axi_memory_bus_AWVALID / AWREADY  out / in  1  AW handshake
- m_axi_memory_bus_WSTRB  out  AXI_WIDTH_DS  all ones
- m_axi_memory_bus_WLAST  out  1  high on beat == len while WVALID
- m_axi_memory_bus_WVALID / WREADY  out / in  1  W handshake
- m_axi_memory_bus_BID  in  AXI_WIDTH_ID  ignored
- m_axi_memory_bus_BRESP  in  2  write response
- m_axi_memory_bus_BVALID / BREADY  in / out  1  B handshake

## Operation
- States: IDLE, AW, LOAD, W, RESP.
- IDLE → AW on start_i. The block latches base_addr_i and len_i, clears beat counter and err_o. start_i is ignored in any other state.
- AW: AWVALID=1; AWADDR/AWLEN stay stable until AWREADY. Transition to LOAD on AWREADY. W is never issued before the AW handshake completes.
- LOAD: wr_en=1, sel=0, one cycle; then W.
- W: WVALID=1; WDATA comes from the mux register loaded on the previous wr_en.
  - On WREADY with beat<len: wr_en=1 combinationally, sel=beat+1, beat increments. WVALID stays high, giving back-to-back beats.
  - On WREADY with beat==len: go to RESP; wr_en=0.
- Without WREADY: wr_en=0 and sel holds, so WDATA is held.
- RESP: BREADY=1. On BVALID: err_o<=BRESP[1], done_o pulses next cycle, state goes to IDLE.
- sel_store_data equals the beat counter in all states except on a W-advance cycle, where it equals beat+1. wr_en=0 outside LOAD/W.
- Upstream must hold stor_*_i stable from the start_i cycle until done_o. The mux input register adds one cycle, which the AW state covers.
- The caller guarantees that base + (len+1)·DS does not cross 4 KB. The block does not split bursts.

## Timing
- Reset values: state IDLE; busy_o, done_o, err_o, wr_en, sel, AWVALID, WVALID, WLAST, BREADY all 0. AWADDR/AWLEN are 0.
- Async reset mid-burst drops every valid/ready immediately and returns the block to IDLE. There is no AXI drain; system reset is assumed global.
- Minimum latency, len=0, all readys high:
  - start at edge 0
  - AWVALID in cycle 1
  - LOAD in cycle 2
  - WVALID+WLAST in cycle 3
  - BREADY in cycle 4
  - done_o in cycle 5 (busy_o low the same cycle)
- Full burst with WREADY constantly high: len+1 consecutive W cycles.
- BVALID may already be asserted when RESP is entered; it is accepted in the first RESP cycle.
- A start_i in the done_o cycle is accepted, since the state is already IDLE.

## Test plan
- Reset check: assert rst during W of a len=7 burst → all valids and busy_o drop within the same cycle; state is IDLE after release.
- Single beat: base=0x1000, len=0, stor_0_i=0xDEADBEEF, all readys high → AWADDR=0x1000, AWLEN=0, one W beat with WDATA=0xDEADBEEF and WLAST=1, done_o in cycle 5.
- Full burst: len=31, stor_k_i=k·0x01010101, WREADY=1 → 32 consecutive beats with WDATA k·0x01010101, WLAST only on beat 31.
- Backpressure: len=3, WREADY toggles 1,0,0,1,0,1,1 → WDATA and sel hold while WREADY=0; beats appear in order 0..3 exactly once.
- AW stall: AWREADY low for 5 cycles → AWVALID held, AWADDR stable, wr_en=0 and WVALID=0 until the handshake.
- Error and restart: BRESP=2'b10 → err_o=1 and done_o pulse. A start_i issued in the done_o cycle → new burst accepted and err_o cleared.
